// File: rtl/ctrl_sequencer.sv
// Hardwired T-state control unit for the single-bus datapath: decodes ir[31:27], steps T0..T7,
// and adds run/halt gating, an optional memory wait handshake with timeout, and an opcode trap.
module ctrl_sequencer #(
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter int MEM_TIMEOUT   = 15,
    parameter int ALU_OP_W      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic [18:0]         ctrl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state_o,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                halted
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        C_LD   = 3'd0,
        C_LDI  = 3'd1,
        C_ST   = 3'd2,
        C_ALUR = 3'd3,
        C_ALUI = 3'd4,
        C_NOP  = 3'd5,
        C_HALT = 3'd6,
        C_ILL  = 3'd7
    } iclass_t;

    localparam int B_PC_OUT    = 0;
    localparam int B_PC_IN     = 1;
    localparam int B_INC_PC    = 2;
    localparam int B_MAR_IN    = 3;
    localparam int B_MDR_IN    = 4;
    localparam int B_MDR_OUT   = 5;
    localparam int B_READ      = 6;
    localparam int B_WRITE     = 7;
    localparam int B_IR_IN     = 8;
    localparam int B_Y_IN      = 9;
    localparam int B_Z_IN      = 10;
    localparam int B_Z_LOW_OUT = 11;
    localparam int B_C_OUT     = 12;
    localparam int B_GRA       = 13;
    localparam int B_GRB       = 14;
    localparam int B_GRC       = 15;
    localparam int B_R_IN      = 16;
    localparam int B_R_OUT     = 17;
    localparam int B_BA_OUT    = 18;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_ROR = 3'd6;
    localparam logic [2:0] ALU_ROL = 3'd7;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    function automatic iclass_t op_class(input logic [4:0] op);
        iclass_t c;
        case (op)
            5'd0:                                    c = C_LD;
            5'd1:                                    c = C_LDI;
            5'd2:                                    c = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10:                 c = C_ALUR;
            5'd11, 5'd12, 5'd13:                     c = C_ALUI;
            5'd26:                                   c = C_NOP;
            5'd27:                                   c = C_HALT;
            default:                                 c = C_ILL;
        endcase
        return c;
    endfunction

    // Address arithmetic of ld/ldi/st also uses Add, which the default arm supplies.
    function automatic logic [2:0] alu_code(input logic [4:0] op);
        logic [2:0] a;
        case (op)
            5'd3:    a = ALU_ADD;
            5'd4:    a = ALU_SUB;
            5'd5:    a = ALU_AND;
            5'd6:    a = ALU_OR;
            5'd7:    a = ALU_SHR;
            5'd8:    a = ALU_SHL;
            5'd9:    a = ALU_ROR;
            5'd10:   a = ALU_ROL;
            5'd11:   a = ALU_ADD;
            5'd12:   a = ALU_AND;
            5'd13:   a = ALU_OR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_op;
    logic [2:0]  r_alu_op;
    logic [7:0]  r_wait_cnt;
    logic        r_bus_error;
    logic [4:0]  w_op;
    iclass_t     w_class;
    logic        w_mem_state;
    logic        w_mem_go;
    logic        w_timeout;
    logic        w_final;
    logic [18:0] w_ctrl;
    logic        w_unused_ir;

    // IR is loaded at the end of T2, so T3 must decode ir live; later states use the copy latched in T3.
    assign w_op    = (r_state == S_T3) ? ir[31:27] : r_op;
    assign w_class = op_class(w_op);
    assign w_unused_ir = ^ir[26:0];

    // Memory T-states, the wait handshake and the last T-state of each instruction class.
    always_comb begin
        w_mem_state = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            S_T1:    w_mem_state = 1'b1;
            S_T3:    w_final     = (w_class == C_NOP) || (w_class == C_ILL);
            S_T5:    w_final     = (w_class == C_LDI) || (w_class == C_ALUR) || (w_class == C_ALUI);
            S_T6:    w_mem_state = (w_class == C_LD);
            S_T7: begin
                w_mem_state = (w_class == C_ST);
                w_final     = 1'b1;
            end
            default: begin
                w_mem_state = 1'b0;
                w_final     = 1'b0;
            end
        endcase
        w_mem_go  = !w_mem_state || !MEM_HANDSHAKE || mem_ready;
        w_timeout = w_mem_state && MEM_HANDSHAKE && !mem_ready && (r_wait_cnt == TIMEOUT_C);
    end

    // Next-state selection; timeout and memory stalls take priority over normal sequencing.
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_HALT;
        end else if (!w_mem_go) begin
            w_next = r_state;
        end else if (w_final) begin
            w_next = run ? S_T0 : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = run ? S_T0 : S_IDLE;
                S_T0:    w_next = S_T1;
                S_T1:    w_next = S_T2;
                S_T2:    w_next = S_T3;
                S_T3:    w_next = (w_class == C_HALT) ? S_HALT : S_T4;
                S_T4:    w_next = S_T5;
                S_T5:    w_next = S_T6;
                S_T6:    w_next = S_T7;
                S_HALT:  w_next = S_HALT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Strobe decode; exactly one bus driver per state, and read/write never share a state.
    always_comb begin
        w_ctrl = 19'd0;
        case (r_state)
            S_T0: begin
                w_ctrl[B_PC_OUT] = 1'b1;
                w_ctrl[B_MAR_IN] = 1'b1;
                w_ctrl[B_INC_PC] = 1'b1;
                w_ctrl[B_Z_IN]   = 1'b1;
            end
            S_T1: begin
                w_ctrl[B_Z_LOW_OUT] = 1'b1;
                w_ctrl[B_PC_IN]     = 1'b1;
                w_ctrl[B_READ]      = 1'b1;
                w_ctrl[B_MDR_IN]    = 1'b1;
            end
            S_T2: begin
                w_ctrl[B_MDR_OUT] = 1'b1;
                w_ctrl[B_IR_IN]   = 1'b1;
            end
            S_T3: begin
                if ((w_class == C_LD) || (w_class == C_LDI) || (w_class == C_ST)) begin
                    w_ctrl[B_GRB]    = 1'b1;
                    w_ctrl[B_BA_OUT] = 1'b1;
                    w_ctrl[B_Y_IN]   = 1'b1;
                end else if ((w_class == C_ALUR) || (w_class == C_ALUI)) begin
                    w_ctrl[B_GRB]   = 1'b1;
                    w_ctrl[B_R_OUT] = 1'b1;
                    w_ctrl[B_Y_IN]  = 1'b1;
                end else begin
                    w_ctrl = 19'd0;
                end
            end
            S_T4: begin
                w_ctrl[B_Z_IN] = 1'b1;
                if (w_class == C_ALUR) begin
                    w_ctrl[B_GRC]   = 1'b1;
                    w_ctrl[B_R_OUT] = 1'b1;
                end else begin
                    w_ctrl[B_C_OUT] = 1'b1;
                end
            end
            S_T5: begin
                w_ctrl[B_Z_LOW_OUT] = 1'b1;
                if ((w_class == C_LD) || (w_class == C_ST)) begin
                    w_ctrl[B_MAR_IN] = 1'b1;
                end else begin
                    w_ctrl[B_GRA]  = 1'b1;
                    w_ctrl[B_R_IN] = 1'b1;
                end
            end
            S_T6: begin
                w_ctrl[B_MDR_IN] = 1'b1;
                if (w_class == C_ST) begin
                    w_ctrl[B_GRA]   = 1'b1;
                    w_ctrl[B_R_OUT] = 1'b1;
                end else begin
                    w_ctrl[B_READ] = 1'b1;
                end
            end
            S_T7: begin
                if (w_class == C_ST) begin
                    w_ctrl[B_WRITE] = 1'b1;
                end else begin
                    w_ctrl[B_MDR_OUT] = 1'b1;
                    w_ctrl[B_GRA]     = 1'b1;
                    w_ctrl[B_R_IN]    = 1'b1;
                end
            end
            default: w_ctrl = 19'd0;
        endcase
    end

    // State register, latched opcode, held alu_op, per-state wait counter and bus_error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 5'd0;
            r_alu_op    <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_bus_error <= w_timeout;
            if (r_state == S_T3) begin
                r_op <= ir[31:27];
            end
            if (w_next == S_T0) begin
                r_alu_op <= ALU_ADD;
            end else if ((r_state == S_T3) && (w_next == S_T4)) begin
                r_alu_op <= alu_code(w_op);
            end
            if (w_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_mem_state && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign ctrl       = w_ctrl;
    assign alu_op     = ALU_OP_W'(r_alu_op);
    assign state_o    = r_state;
    assign instr_done = w_final && w_mem_go;
    assign illegal_op = (r_state == S_T3) && (w_class == C_ILL);
    assign bus_error  = r_bus_error;
    assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: one DUT without the memory handshake, one with it (timeout 4).
module tb_ctrl_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n = 1'b0;
    logic        rst_b_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = 32'd0;

    logic [18:0] ctrl_a, ctrl_b;
    logic [3:0]  alu_a, alu_b, st_a, st_b;
    logic        done_a, done_b, ill_a, ill_b, berr_a, berr_b, halt_a, halt_b;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_sequencer #(.MEM_HANDSHAKE(1'b0), .MEM_TIMEOUT(15), .ALU_OP_W(4)) u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .run(run), .ir(ir), .mem_ready(mem_ready),
        .ctrl(ctrl_a), .alu_op(alu_a), .state_o(st_a), .instr_done(done_a),
        .illegal_op(ill_a), .bus_error(berr_a), .halted(halt_a)
    );

    ctrl_sequencer #(.MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(4), .ALU_OP_W(4)) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .run(run), .ir(ir), .mem_ready(mem_ready),
        .ctrl(ctrl_b), .alu_op(alu_b), .state_o(st_b), .instr_done(done_b),
        .illegal_op(ill_b), .bus_error(berr_b), .halted(halt_b)
    );

    // State codes: IDLE=0, T0..T7=1..8, HALT=15
    localparam logic [18:0] LD_CTRL [0:7] = '{19'h0040D, 19'h00852, 19'h00120, 19'h44200,
                                              19'h01400, 19'h00808, 19'h00050, 19'h12020};

    localparam logic [3:0]  MW_ST   [0:15] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4,
                                               4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 4'd7, 4'd8, 4'd0};
    localparam logic [18:0] MW_CTRL [0:15] = '{19'h0040D, 19'h00852, 19'h00852, 19'h00852,
                                               19'h00852, 19'h00852, 19'h00120, 19'h44200,
                                               19'h01400, 19'h00808, 19'h00050, 19'h00050,
                                               19'h00050, 19'h00050, 19'h12020, 19'h00000};
    localparam logic        MW_RDY  [0:15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    localparam logic [3:0]  BB_ST   [0:17] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3,
                                               4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15, 4'd15};
    localparam logic [18:0] BB_CTRL [0:17] = '{19'h0040D, 19'h00852, 19'h00120, 19'h24200,
                                               19'h28400, 19'h12800, 19'h0040D, 19'h00852,
                                               19'h00120, 19'h24200, 19'h01400, 19'h12800,
                                               19'h0040D, 19'h00852, 19'h00120, 19'h00000,
                                               19'h00000, 19'h00000};
    localparam logic [3:0]  BB_ALU  [0:17] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                                               4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};

    localparam logic [18:0] ST_CTRL [0:6] = '{19'h0040D, 19'h00852, 19'h00120, 19'h44200,
                                              19'h01400, 19'h00808, 19'h22010};

    task automatic reset_to(input bit sel_b);
        @(negedge clk);
        rst_a_n = 1'b0; rst_b_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        if (sel_b) rst_b_n = 1'b1;
        else       rst_a_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ctrl_a, alu_a, st_a} !== 27'd0) begin
            n_fail++; $display("FAIL reset_a ctrl/alu/state got=%h/%0d/%0d exp=0/0/0", ctrl_a, alu_a, st_a);
        end
        n_checks++;
        if ({done_a, ill_a, berr_a, halt_a} !== 4'd0) begin
            n_fail++; $display("FAIL reset_a_flags got=%b exp=0000", {done_a, ill_a, berr_a, halt_a});
        end
        n_checks++;
        if ({ctrl_b, alu_b, st_b, done_b, ill_b, berr_b, halt_b} !== 31'd0) begin
            n_fail++; $display("FAIL reset_b got ctrl=%h alu=%0d st=%0d exp all 0", ctrl_b, alu_b, st_b);
        end
        run = 1'b0;
    endtask

    task automatic test_ld;
        reset_to(1'b0);
        ir = 32'h0080_0085; run = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_a !== 4'(c + 1)) begin
                n_fail++; $display("FAIL ld_state cyc=%0d got=%0d exp=%0d", c, st_a, c + 1);
            end
            n_checks++;
            if (ctrl_a !== LD_CTRL[c]) begin
                n_fail++; $display("FAIL ld_ctrl cyc=%0d got=%h exp=%h", c, ctrl_a, LD_CTRL[c]);
            end
            n_checks++;
            if (done_a !== (c == 7)) begin
                n_fail++; $display("FAIL ld_done cyc=%0d got=%b exp=%b", c, done_a, (c == 7));
            end
            n_checks++;
            if (alu_a !== 4'd2) begin
                n_fail++; $display("FAIL ld_alu cyc=%0d got=%0d exp=2", c, alu_a);
            end
            if (c == 1) run = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_a !== 4'd0 || ctrl_a !== 19'd0) begin
                n_fail++; $display("FAIL ld_idle cyc=%0d got st=%0d ctrl=%h exp st=0 ctrl=0", c, st_a, ctrl_a);
            end
        end
    endtask

    task automatic test_mem_wait;
        reset_to(1'b1);
        ir = 32'h0008_0035; run = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_b !== MW_ST[c]) begin
                n_fail++; $display("FAIL mw_state cyc=%0d got=%0d exp=%0d", c, st_b, MW_ST[c]);
            end
            n_checks++;
            if (ctrl_b !== MW_CTRL[c]) begin
                n_fail++; $display("FAIL mw_ctrl cyc=%0d got=%h exp=%h", c, ctrl_b, MW_CTRL[c]);
            end
            n_checks++;
            if (berr_b !== 1'b0 || done_b !== (c == 14)) begin
                n_fail++; $display("FAIL mw_flags cyc=%0d got berr=%b done=%b exp berr=0 done=%b",
                                   c, berr_b, done_b, (c == 14));
            end
            mem_ready = MW_RDY[c];
            if (c == 1) run = 1'b0;
        end
    endtask

    task automatic test_timeout;
        reset_to(1'b1);
        ir = 32'h0080_0085; run = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (c == 0 && st_b !== 4'd1) begin
                n_fail++; $display("FAIL to_t0 got=%0d exp=1", st_b);
            end else if (c >= 1 && c <= 5 && (st_b !== 4'd2 || ctrl_b !== 19'h00852)) begin
                n_fail++; $display("FAIL to_wait cyc=%0d got st=%0d ctrl=%h exp st=2 ctrl=852", c, st_b, ctrl_b);
            end else if (c >= 6 && (st_b !== 4'd15 || halt_b !== 1'b1 || ctrl_b !== 19'd0)) begin
                n_fail++; $display("FAIL to_halt cyc=%0d got st=%0d halted=%b ctrl=%h exp 15/1/0", c, st_b, halt_b, ctrl_b);
            end
            n_checks++;
            if (berr_b !== (c == 6)) begin
                n_fail++; $display("FAIL to_berr cyc=%0d got=%b exp=%b", c, berr_b, (c == 6));
            end
        end
    endtask

    task automatic test_back_to_back;
        reset_to(1'b0);
        ir = 32'h1800_0000; run = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_a !== BB_ST[c] || ctrl_a !== BB_CTRL[c]) begin
                n_fail++; $display("FAIL bb_seq cyc=%0d got st=%0d ctrl=%h exp st=%0d ctrl=%h",
                                   c, st_a, ctrl_a, BB_ST[c], BB_CTRL[c]);
            end
            n_checks++;
            if (alu_a !== BB_ALU[c]) begin
                n_fail++; $display("FAIL bb_alu cyc=%0d got=%0d exp=%0d", c, alu_a, BB_ALU[c]);
            end
            n_checks++;
            if (halt_a !== (c >= 16) || ill_a !== 1'b0) begin
                n_fail++; $display("FAIL bb_halt cyc=%0d got halted=%b illegal=%b exp %b/0", c, halt_a, ill_a, (c >= 16));
            end
            if (c != 15) begin
                n_checks++;
                if (done_a !== (c == 5 || c == 11)) begin
                    n_fail++; $display("FAIL bb_done cyc=%0d got=%b exp=%b", c, done_a, (c == 5 || c == 11));
                end
            end
            if (c == 4)  ir = 32'h6800_0000;
            if (c == 10) ir = 32'hD800_0000;
        end
    endtask

    task automatic test_illegal;
        reset_to(1'b0);
        ir = 32'hF800_0000; run = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (ill_a !== 1'b1 || done_a !== 1'b1 || ctrl_a !== 19'd0) begin
                    n_fail++; $display("FAIL ill_t3 got illegal=%b done=%b ctrl=%h exp 1/1/0", ill_a, done_a, ctrl_a);
                end
            end else if (c == 4) begin
                n_checks++;
                if (st_a !== 4'd1 || ill_a !== 1'b0) begin
                    n_fail++; $display("FAIL ill_next got st=%0d illegal=%b exp 1/0", st_a, ill_a);
                end
                ir = 32'hD000_0000; run = 1'b0;
            end else if (c == 7) begin
                n_checks++;
                if (st_a !== 4'd4 || ill_a !== 1'b0 || done_a !== 1'b1 || ctrl_a !== 19'd0) begin
                    n_fail++; $display("FAIL nop_t3 got st=%0d illegal=%b done=%b ctrl=%h exp 4/0/1/0",
                                       st_a, ill_a, done_a, ctrl_a);
                end
            end else if (c == 8) begin
                n_checks++;
                if (st_a !== 4'd0) begin
                    n_fail++; $display("FAIL nop_idle got=%0d exp=0", st_a);
                end
            end else begin
                n_checks++;
                if (ill_a !== 1'b0) begin
                    n_fail++; $display("FAIL ill_quiet cyc=%0d got=%b exp=0", c, ill_a);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        reset_to(1'b0);
        ir = 32'h1000_0000; run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_a !== 4'(c + 1) || ctrl_a !== ST_CTRL[c]) begin
                n_fail++; $display("FAIL st_seq cyc=%0d got st=%0d ctrl=%h exp st=%0d ctrl=%h",
                                   c, st_a, ctrl_a, c + 1, ST_CTRL[c]);
            end
            if (c == 1) run = 1'b0;
        end
        #2 rst_a_n = 1'b0;
        #1;
        n_checks++;
        if (ctrl_a !== 19'd0 || st_a !== 4'd0 || alu_a !== 4'd0) begin
            n_fail++; $display("FAIL async_rst got ctrl=%h st=%0d alu=%0d exp 0/0/0", ctrl_a, st_a, alu_a);
        end
        @(negedge clk);
        rst_a_n = 1'b1; run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (st_a !== 4'd0 || ctrl_a !== 19'd0 || done_a !== 1'b0) begin
                n_fail++; $display("FAIL post_rst_idle cyc=%0d got st=%0d ctrl=%h done=%b exp 0/0/0",
                                   c, st_a, ctrl_a, done_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
